// File: rtl/dbus_sram_responder_if.sv
// Request/acknowledge signals of one device_bus target port.
// The bidirectional DATA bus is kept outside as a plain inout net.
interface dbus_sram_responder_if;
  logic        EN;
  logic        RE;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] ADDR;
  logic        RACK;
  logic        WACK;
  logic        BUSY;

  modport master (
    output EN, RE, WE, BE, ADDR,
    input  RACK, WACK, BUSY
  );

  modport slave (
    input  EN, RE, WE, BE, ADDR,
    output RACK, WACK, BUSY
  );
endinterface

// File: rtl/dbus_sram_responder.sv
// Word-organised RAM behind the device_bus with byte-enable writes and
// programmable read/write wait states.
module dbus_sram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned RD_WAIT   = 0,
  parameter int unsigned WR_WAIT   = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic                 XCLK,
  input  logic                 XRES,
  dbus_sram_responder_if.slave bus,
  inout  wire  [31:0]          DATA
);
  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam logic [3:0]  RD_LOAD = 4'(RD_WAIT);
  localparam logic [3:0]  WR_LOAD = 4'(WR_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 rack_q, rack_d;
  logic                 wack_q, wack_d;
  logic                 busy_q, busy_d;
  logic                 drive_q, drive_d;

  logic                 hit;
  logic                 accept;
  logic [3:0]           load_cnt;
  logic                 commit;
  logic                 commit_wr;
  logic [ADDR_BITS-1:0] commit_idx;
  logic [3:0]           commit_be;
  logic [31:0]          commit_wdata;

  logic [31:0]          mem [DEPTH];
  logic [31:0]          rd_word_q;

  logic                 unused_addr_lsb;
  assign unused_addr_lsb = ^bus.ADDR[1:0];

  assign hit      = (bus.ADDR[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign accept   = (state_q == S_IDLE) && bus.EN && hit && (bus.RE || bus.WE);
  assign load_cnt = bus.WE ? WR_LOAD : RD_LOAD;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_wr_d      = op_wr_q;
    idx_d        = idx_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    commit       = 1'b0;
    commit_wr    = op_wr_q;
    commit_idx   = idx_q;
    commit_be    = be_q;
    commit_wdata = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_wr_d = bus.WE;
          idx_d   = bus.ADDR[ADDR_BITS+1:2];
          be_d    = bus.BE;
          wdata_d = DATA;
          cnt_d   = load_cnt;
          if (load_cnt != 4'd0) begin
            state_d = S_WAIT;
          end else begin
            // zero-wait requests commit straight from the live bus
            commit       = 1'b1;
            commit_wr    = bus.WE;
            commit_idx   = bus.ADDR[ADDR_BITS+1:2];
            commit_be    = bus.BE;
            commit_wdata = DATA;
            state_d      = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (!bus.EN) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          commit  = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rack_d  = commit && !commit_wr;
    wack_d  = commit && commit_wr;
    drive_d = commit && !commit_wr;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rack_q  <= 1'b0;
      wack_q  <= 1'b0;
      busy_q  <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rack_q  <= rack_d;
      wack_q  <= wack_d;
      busy_q  <= busy_d;
      drive_q <= drive_d;
    end
  end

  // Single-port RAM: one write or one registered read per commit edge.
  // Reset blocks the commit so an aborted request never lands in memory.
  always_ff @(posedge XCLK) begin
    if (!XRES && commit) begin
      if (commit_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (commit_be[b]) begin
            mem[commit_idx][b*8 +: 8] <= commit_wdata[b*8 +: 8];
          end
        end
      end else begin
        rd_word_q <= mem[commit_idx];
      end
    end
  end

  assign bus.RACK = rack_q;
  assign bus.WACK = wack_q;
  assign bus.BUSY = busy_q;
  assign DATA     = drive_q ? rd_word_q : 32'bz;
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: three instances with different decode and
// wait-state settings, a vector table plus hand-written abort/reset sequences.
module tb_dbus_sram_responder;
  localparam logic [31:0] BASES [3] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_0000};
  localparam int          RDW   [3] = '{0, 3, 1};
  localparam int          WRW   [3] = '{0, 2, 5};
  // DATA nets are pulled up, so an undriven bus reads as all ones
  localparam logic [31:0] FLOAT = 32'hFFFF_FFFF;

  logic        XCLK = 1'b0;
  logic        XRES = 1'b1;
  int          sel  = 0;
  logic        en   = 1'b0;
  logic        re   = 1'b0;
  logic        we   = 1'b0;
  logic [3:0]  be   = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        tb_oe = 1'b0;

  logic [2:0]  rack_v, wack_v, busy_v;
  logic [31:0] data_v [3];
  logic        rack_s, wack_s, busy_s;
  logic [31:0] data_s;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          k;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    bit          hit;
    logic [31:0] expd;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [31:0] data;
    int          lat;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];

  always #5 XCLK = ~XCLK;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      wire [31:0] data_w;
      pullup (data_w);
      dbus_sram_responder_if u_if ();

      assign u_if.EN   = en && (sel == gi);
      assign u_if.RE   = re;
      assign u_if.WE   = we;
      assign u_if.BE   = be;
      assign u_if.ADDR = addr;
      assign data_w    = (tb_oe && sel == gi) ? wdata : 32'bz;

      assign rack_v[gi] = u_if.RACK;
      assign wack_v[gi] = u_if.WACK;
      assign busy_v[gi] = u_if.BUSY;
      assign data_v[gi] = data_w;

      dbus_sram_responder #(
        .BASE_ADDR (BASES[gi]),
        .ADDR_BITS (10),
        .RD_WAIT   (RDW[gi]),
        .WR_WAIT   (WRW[gi]),
        .INIT_FILE ("")
      ) u_dut (
        .XCLK (XCLK),
        .XRES (XRES),
        .bus  (u_if.slave),
        .DATA (data_w)
      );
    end
  endgenerate

  assign rack_s = rack_v[sel];
  assign wack_s = wack_v[sel];
  assign busy_s = busy_v[sel];
  assign data_s = data_v[sel];

  task automatic tick();
    @(posedge XCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic release_bus();
    en = 1'b0; re = 1'b0; we = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   waitc;
    int   limit;
    bit   acked;
    sb_t  e;
    sel = v.k; en = 1'b1; re = !v.wr; we = v.wr;
    addr = v.addr; be = v.be; wdata = v.data; tb_oe = v.wr;
    waitc = v.wr ? WRW[v.k] : RDW[v.k];
    if (v.hit) sb_q.push_back('{wr: v.wr, data: v.expd, lat: 1 + waitc});
    limit = v.hit ? 24 : 8;
    acked = 1'b0;
    for (int c = 1; c <= limit && !acked; c++) begin
      tick();
      if (rack_s || wack_s) begin
        acked = 1'b1;
        if (sb_q.size() == 0) begin
          check("unexpected_ack", {30'd0, rack_s, wack_s}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("ack_kind", {30'd0, rack_s, wack_s}, {30'd0, !e.wr, e.wr});
          check("ack_cycle", c, e.lat);
          check("ack_busy", {31'd0, busy_s}, 32'd1);
          if (!e.wr) check("rd_data", data_s, e.data);
        end
      end else begin
        check("busy_pending", {31'd0, busy_s}, {31'd0, v.hit});
        if (!v.wr) check("data_float", data_s, FLOAT);
      end
    end
    if (v.hit && !acked) begin
      check("ack_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end
    release_bus();
    tick();
    check("post_ack_idle", {29'd0, rack_s, wack_s, busy_s}, 32'd0);
    check("post_ack_float", data_s, FLOAT);
    $display("txn dut%0d %s addr=%h be=%b data=%h hit=%0d acked=%0d",
             v.k, v.wr ? "WR" : "RD", v.addr, v.be, v.data, v.hit, acked);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // dut0: base 0, zero wait states
    vecs.push_back('{0, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{0, 1'b1, 32'h0000_0010, 4'b0010, 32'h0000_AA00, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         1'b1, 32'hDEAD_AAEF});
    vecs.push_back('{0, 1'b1, 32'h0000_0010, 4'b0000, 32'h1234_5678, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         1'b1, 32'hDEAD_AAEF});
    vecs.push_back('{0, 1'b1, 32'h0000_0020, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b1, 32'h0000_0020, 4'b0101, 32'h0055_0066, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h0000_0023, 4'b0000, 32'h0,         1'b1, 32'hCA55_F066});
    vecs.push_back('{0, 1'b1, 32'h0000_0FFC, 4'b1111, 32'h0BAD_C0DE, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h0000_0FFC, 4'b0000, 32'h0,         1'b1, 32'h0BAD_C0DE});
    vecs.push_back('{0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,         1'b0, 32'h0});
    // dut1: base 0x1000, RD_WAIT=3, WR_WAIT=2
    vecs.push_back('{1, 1'b1, 32'h0000_1FFC, 4'b1111, 32'hA5A5_5A5A, 1'b1, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h0000_1FFE, 4'b0000, 32'h0,         1'b1, 32'hA5A5_5A5A});
    vecs.push_back('{1, 1'b0, 32'h0000_0800, 4'b0000, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{1, 1'b1, 32'h0000_2000, 4'b1111, 32'h7777_7777, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b1, 32'h0000_1000, 4'b1111, 32'h0102_0304, 1'b1, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,         1'b1, 32'h0102_0304});
    // dut2: base 0, RD_WAIT=1, WR_WAIT=5
    vecs.push_back('{2, 1'b1, 32'h0000_0040, 4'b1111, 32'h600D_F00D, 1'b1, 32'h0});
    vecs.push_back('{2, 1'b0, 32'h0000_0040, 4'b0000, 32'h0,         1'b1, 32'h600D_F00D});

    repeat (3) tick();
    XRES = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      check("reset_outputs", {29'd0, rack_s, wack_s, busy_s}, 32'd0);
      check("reset_data_float", data_s, FLOAT);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // read held with EN=1 through ACK: re-accepted only at the next IDLE edge
    sel = 0; en = 1'b1; re = 1'b1; we = 1'b0; addr = 32'h0000_0010;
    tick();
    check("held_first_rack", {31'd0, rack_s}, 32'd1);
    check("held_first_data", data_s, 32'hDEAD_AAEF);
    tick();
    check("held_gap_rack", {31'd0, rack_s}, 32'd0);
    check("held_gap_busy", {31'd0, busy_s}, 32'd0);
    check("held_gap_float", data_s, FLOAT);
    tick();
    check("held_second_rack", {31'd0, rack_s}, 32'd1);
    check("held_second_data", data_s, 32'hDEAD_AAEF);
    release_bus();
    tick();
    $display("txn dut0 RD held-through-ack addr=00000010");

    // read abort on dut1: EN dropped in cycle t+2
    sel = 1; en = 1'b1; re = 1'b1; addr = 32'h0000_1000;
    tick();
    check("abort_rd_busy_t1", {31'd0, busy_s}, 32'd1);
    tick();
    check("abort_rd_busy_t2", {31'd0, busy_s}, 32'd1);
    release_bus();
    for (int c = 0; c < 6; c++) begin
      tick();
      check("abort_rd_quiet", {29'd0, rack_s, wack_s, busy_s}, 32'd0);
      check("abort_rd_float", data_s, FLOAT);
    end
    $display("txn dut1 RD aborted addr=00001000");

    // write abort on dut1: EN dropped in cycle t+1, memory must keep old word
    sel = 1; en = 1'b1; we = 1'b1; be = 4'b1111; addr = 32'h0000_1000;
    wdata = 32'hFFFF_0000; tb_oe = 1'b1;
    tick();
    check("abort_wr_busy_t1", {31'd0, busy_s}, 32'd1);
    release_bus();
    for (int c = 0; c < 5; c++) begin
      tick();
      check("abort_wr_quiet", {29'd0, rack_s, wack_s, busy_s}, 32'd0);
    end
    $display("txn dut1 WR aborted addr=00001000");
    v = '{1, 1'b0, 32'h0000_1000, 4'b0000, 32'h0, 1'b1, 32'h0102_0304};
    run_vec(v);

    // reset pulsed mid-WAIT on dut2 (WR_WAIT=5)
    sel = 2; en = 1'b1; we = 1'b1; be = 4'b1111; addr = 32'h0000_0040;
    wdata = 32'hBAD0_BAD0; tb_oe = 1'b1;
    tick();
    check("rst_mid_busy_t1", {31'd0, busy_s}, 32'd1);
    tick();
    XRES = 1'b1;
    tick();
    XRES = 1'b0;
    release_bus();
    check("rst_mid_outputs", {29'd0, rack_s, wack_s, busy_s}, 32'd0);
    for (int c = 0; c < 8; c++) begin
      tick();
      check("rst_mid_quiet", {29'd0, rack_s, wack_s, busy_s}, 32'd0);
    end
    $display("txn dut2 WR reset-aborted addr=00000040");
    v = '{2, 1'b0, 32'h0000_0040, 4'b0000, 32'h0, 1'b1, 32'h600D_F00D};
    run_vec(v);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
